// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
//   Receiving end of the hasher's golden-nonce report path (hash_clk domain).
//   Each single-cycle golden-nonce strobe is tagged with the current
//   work-generation number and queued, so that no result is lost while the
//   JTAG comm side is slow to drain. Entries leave through a
//   first-word-fall-through valid/ready port.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   TAG_W  width of the wrapping work-generation tag
//   OVF_W  width of the saturating dropped-nonce counter
//
// Ports
//   hash_clk      in   hasher clock, rising edge
//   reset         in   synchronous, active-high
//   in_valid      in   golden-nonce strobe, one cycle per nonce
//   in_nonce      in   [31:0] nonce qualified by in_valid
//   new_work      in   pulse: new work loaded, advances the tag
//   out_valid     out  head entry available
//   out_nonce     out  [31:0] head nonce
//   out_tag       out  [TAG_W-1:0] head tag
//   out_ready     in   consumer accepts the head when out_valid=1
//   level         out  [$clog2(DEPTH):0] occupancy, 0..DEPTH
//   full          out  level == DEPTH
//   overflow_cnt  out  [OVF_W-1:0] nonces dropped on a full queue, saturating
//
// Configuration
//   GOLDEN_NONCE_QUEUE_DEDUP_EN  when defined, a strobe whose {tag,nonce}
//   equals the last accepted entry is silently discarded.

module golden_nonce_queue #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4,
    parameter int OVF_W = 16
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_nonce,
    input  logic                     new_work,
    output logic                     out_valid,
    output logic [31:0]              out_nonce,
    output logic [TAG_W-1:0]         out_tag,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [OVF_W-1:0]         overflow_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = TAG_W + 32;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [TAG_W-1:0]   cur_tag;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] new_entry;

    logic accept;
    logic push;
    logic pop;
    logic drop;

    assign new_entry = {cur_tag, in_nonce};

`ifdef GOLDEN_NONCE_QUEUE_DEDUP_EN
    logic               last_valid;
    logic [ENTRY_W-1:0] last_entry;

    // The duplicate compare sits ahead of the full check, so a repeat on a
    // full queue is swallowed instead of being counted as a drop.
    assign accept = in_valid && !(last_valid && (new_entry == last_entry));

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            last_valid <= 1'b0;
        end else if (push) begin
            last_valid <= 1'b1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (push) begin
            last_entry <= new_entry;
        end
    end
`else
    assign accept = in_valid;
`endif

    // A push on a full queue is allowed when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = accept && (!full || pop);
    assign drop = accept && full && !pop;

    assign full      = (level == DEPTH_LVL);
    assign out_valid = (level != '0);

    // Head is read straight from storage (first-word fall-through). It cannot
    // change under a stalled consumer: a write only lands on rd_ptr when the
    // queue is empty, or when full together with a pop.
    assign head      = mem[rd_ptr];
    assign out_nonce = out_valid ? head[31:0] : 32'd0;
    assign out_tag   = out_valid ? head[ENTRY_W-1:32] : '0;

    // Storage is deliberately not reset.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            cur_tag      <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // The entry written this cycle already captured the old tag.
            if (new_work) begin
                cur_tag <= cur_tag + TAG_W'(1);
            end
            if (drop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + OVF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// tb_golden_nonce_queue
//   Directed bench for golden_nonce_queue (DEPTH=16, TAG_W=4, OVF_W=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_golden_nonce_queue;

    logic        hash_clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_nonce;
    logic        new_work;
    logic        out_valid;
    logic [31:0] out_nonce;
    logic [3:0]  out_tag;
    logic        out_ready;
    logic [4:0]  level;
    logic        full;
    logic [15:0] overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    golden_nonce_queue #(.DEPTH(16), .TAG_W(4), .OVF_W(16)) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_nonce     (in_nonce),
        .new_work     (new_work),
        .out_valid    (out_valid),
        .out_nonce    (out_nonce),
        .out_tag      (out_tag),
        .out_ready    (out_ready),
        .level        (level),
        .full         (full),
        .overflow_cnt (overflow_cnt)
    );

    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1; in_nonce = 32'hDEAD_0000; new_work = 1'b1; out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0; in_valid = 1'b0; new_work = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_ovf: got %0d want 0", overflow_cnt); end
        n_checks++; if (out_nonce !== 32'd0) begin n_fail++; $display("FAIL reset_out_nonce: got %h want 0", out_nonce); end
        n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    endtask

    task automatic test_push_order();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_nonce = 32'(i);
            step();
            if (i == 1) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_push_latency: out_valid got %b want 1", out_valid); end
            end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL push3_level: got %0d want 3", level); end
        n_checks++; if (out_nonce !== 32'h1) begin n_fail++; $display("FAIL push3_head: got %h want 00000001", out_nonce); end
        n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL push3_tag: got %0d want 0", out_tag); end
    endtask

    task automatic test_pop_order();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            n_checks++; if (out_nonce !== 32'(i)) begin n_fail++; $display("FAIL pop_order_%0d: got %h want %h", i, out_nonce, 32'(i)); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL pop_empty_level: got %0d want 0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty_valid: got %b want 0", out_valid); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL ready_on_empty: level got %0d want 0", level); end
    endtask

    task automatic test_tag();
        in_valid = 1'b1; in_nonce = 32'hA41F_32E7; new_work = 1'b1;
        step();
        in_nonce = 32'h0000_BEEF; new_work = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL tag_old_on_newwork: got %0d want 0", out_tag); end
        n_checks++; if (out_nonce !== 32'hA41F_32E7) begin n_fail++; $display("FAIL tag_head_nonce: got %h want a41f32e7", out_nonce); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_tag !== 4'd1) begin n_fail++; $display("FAIL tag_advanced: got %0d want 1", out_tag); end
        n_checks++; if (out_nonce !== 32'h0000_BEEF) begin n_fail++; $display("FAIL tag_second_nonce: got %h want 0000beef", out_nonce); end
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            new_work = 1'b1;
            step();
        end
        new_work = 1'b0;
        in_valid = 1'b1; in_nonce = 32'h0000_0055;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_tag !== 4'd1) begin n_fail++; $display("FAIL tag_wrap: got %0d want 1", out_tag); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_nonce = 32'h100 + 32'(i);
            step();
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
        for (int i = 0; i < 2; i++) begin
            in_nonce = 32'h200 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d want 16", level); end
        n_checks++; if (overflow_cnt !== 16'd2) begin n_fail++; $display("FAIL full_ovf: got %0d want 2", overflow_cnt); end
        n_checks++; if (out_nonce !== 32'h100) begin n_fail++; $display("FAIL full_head: got %h want 00000100", out_nonce); end
        in_valid = 1'b1; in_nonce = 32'h999; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_pushpop_level: got %0d want 16", level); end
        n_checks++; if (overflow_cnt !== 16'd2) begin n_fail++; $display("FAIL full_pushpop_ovf: got %0d want 2", overflow_cnt); end
        n_checks++; if (out_nonce !== 32'h101) begin n_fail++; $display("FAIL full_pushpop_head: got %h want 00000101", out_nonce); end
        // Drain 15 entries; the 16th is the nonce accepted during push+pop.
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        out_ready = 1'b0;
        n_checks++; if (out_nonce !== 32'h999) begin n_fail++; $display("FAIL full_wrap_entry: got %h want 00000999", out_nonce); end
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL full_drain_level: got %0d want 1", level); end
    endtask

    task automatic test_reset_mid();
        // Queue holds one entry and overflow_cnt=2; add 4 more and bump the tag.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_nonce = 32'h300 + 32'(i); new_work = 1'b1;
            step();
        end
        in_valid = 1'b0; new_work = 1'b0;
        n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 5", level); end
        reset = 1'b1; in_valid = 1'b1; in_nonce = 32'h777; new_work = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; new_work = 1'b0; out_ready = 1'b0;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_ovf: got %0d want 0", overflow_cnt); end
        in_valid = 1'b1; in_nonce = 32'h0000_0ABC;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_tag !== 4'd0) begin n_fail++; $display("FAIL mid_tag: got %0d want 0", out_tag); end
        n_checks++; if (out_nonce !== 32'h0000_0ABC) begin n_fail++; $display("FAIL mid_first_entry: got %h want 00000abc", out_nonce); end
    endtask

    task automatic test_dedup();
        logic [4:0] exp_after_two;
        logic [4:0] exp_after_three;
`ifdef GOLDEN_NONCE_QUEUE_DEDUP_EN
        exp_after_two   = 5'd1;
        exp_after_three = 5'd2;
`else
        exp_after_two   = 5'd2;
        exp_after_three = 5'd3;
`endif
        do_reset();
        in_valid = 1'b1; in_nonce = 32'h1234_5678;
        step();
        step();
        in_valid = 1'b0;
        n_checks++; if (level !== exp_after_two) begin n_fail++; $display("FAIL dedup_same_tag: level got %0d want %0d", level, exp_after_two); end
        new_work = 1'b1;
        step();
        new_work = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (level !== exp_after_three) begin n_fail++; $display("FAIL dedup_new_tag: level got %0d want %0d", level, exp_after_three); end
        n_checks++; if (overflow_cnt !== 16'd0) begin n_fail++; $display("FAIL dedup_ovf: got %0d want 0", overflow_cnt); end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_nonce = 32'd0; new_work = 1'b0; out_ready = 1'b0;
        test_reset();
        test_push_order();
        test_pop_order();
        test_tag();
        test_full();
        test_reset_mid();
        test_dedup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
